mac_job_scheduler: RTL and testbench

- Shares one three-operand multiply-add datapath (result = a*b + c) between NUM_REQ requesters.
- Grants requesters round-robin and serialises each job's operands onto the datapath stream as a, b, c on three consecutive validi cycles.
- Captures the datapath result on valido and returns it, tagged with the requester ID.
- Sits directly in front of the multiply-add unit and drives its validi/data_in inputs.

---
 rtl/mac_sched_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/mac_job_scheduler.sv | 143 ++++++++++++++
 tb/tb_mac_job_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// Shared types and helpers for the multiply-add job scheduler.
package mac_sched_pkg;

  localparam int unsigned DW_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    SEND_C,
    WAIT,
    RESP
  } sched_state_t;

  // Width of an encoded requester ID; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter
  import mac_sched_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [id_w(N)-1:0]  ptr,
  output logic [N-1:0]        gnt_oh,
  output logic [id_w(N)-1:0]  gnt_id,
  output logic                any
);

  localparam int unsigned IW = id_w(N);

  // Scan offsets from the pointer outward; the first hit wins.
  always_comb begin
    gnt_oh = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!any && req[j] && (j == ((32'(ptr) + k) % N))) begin
          any       = 1'b1;
          gnt_oh[j] = 1'b1;
          gnt_id    = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mac_job_scheduler.sv
// Round-robin job scheduler in front of a shared a*b+c datapath.
module mac_job_scheduler
  import mac_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = DW_DEFAULT,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DW-1:0]      req_a,
  input  logic [NUM_REQ*DW-1:0]      req_b,
  input  logic [NUM_REQ*DW-1:0]      req_c,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [DW-1:0]              resp_data,
  output logic                       resp_err,
  output logic                       validi,
  output logic [DW-1:0]              data_in,
  input  logic                       valido,
  input  logic [DW-1:0]              data_out
);

  localparam int unsigned   IW     = id_w(NUM_REQ);
  localparam int unsigned   CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  sched_state_t        state, state_nxt;
  logic [IW-1:0]       ptr, cur_id, arb_id;
  logic [NUM_REQ-1:0]  cur_oh, arb_oh;
  logic                arb_any;
  logic [DW-1:0]       op_a, op_b, op_c, result;
  logic [DW-1:0]       sel_a, sel_b, sel_c;
  logic                err;
  logic [CW-1:0]       cnt;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .gnt_oh (arb_oh),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  // One-hot operand mux driven by the arbiter grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_oh[i]) begin
        sel_a = sel_a | req_a[i*DW +: DW];
        sel_b = sel_b | req_b[i*DW +: DW];
        sel_c = sel_c | req_c[i*DW +: DW];
      end
    end
  end

  // State register, job capture, timeout counter and RR pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      cur_id <= '0;
      cur_oh <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_c   <= '0;
      result <= '0;
      err    <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (arb_any) begin
            cur_id <= arb_id;
            cur_oh <= arb_oh;
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_c   <= sel_c;
          end
        end
        SEND_C: begin
          cnt <= CW'(1);
          err <= 1'b0;
        end
        WAIT: begin
          if (valido)             result <= data_out;
          else if (cnt == TO_CNT) err    <= 1'b1;
          else                    cnt    <= cnt + 1'b1;
        end
        RESP: begin
          ptr <= (cur_id == IW'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and Moore outputs; all buses forced to zero outside their states.
  always_comb begin
    state_nxt  = state;
    gnt        = '0;
    validi     = 1'b0;
    data_in    = '0;
    resp_valid = 1'b0;
    resp_id    = '0;
    resp_data  = '0;
    resp_err   = 1'b0;
    case (state)
      IDLE: if (arb_any) state_nxt = SEND_A;
      SEND_A: begin
        validi    = 1'b1;
        data_in   = op_a;
        gnt       = cur_oh;
        state_nxt = SEND_B;
      end
      SEND_B: begin
        validi    = 1'b1;
        data_in   = op_b;
        state_nxt = SEND_C;
      end
      SEND_C: begin
        validi    = 1'b1;
        data_in   = op_c;
        state_nxt = WAIT;
      end
      WAIT: if (valido || cnt == TO_CNT) state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        resp_id    = cur_id;
        resp_err   = err;
        resp_data  = err ? '0 : result;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Directed bench for mac_job_scheduler with a behavioural a*b+c datapath stub.
module tb_mac_job_scheduler;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = '0;
  logic [127:0]  req_a = '0, req_b = '0, req_c = '0;
  logic [3:0]    gnt;
  logic          resp_valid;
  logic [1:0]    resp_id;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic          validi;
  logic [31:0]   data_in;
  logic          valido;
  logic [31:0]   data_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic          stub_en = 1'b1;
  logic          spur    = 1'b0;
  logic [31:0]   sa, sb;
  int            scnt;

  mac_job_scheduler #(.NUM_REQ(4), .DW(32), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .validi     (validi),
    .data_in    (data_in),
    .valido     (valido),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stub: collects a, b, c and answers one cycle after c.
  always @(posedge clk) begin
    if (rst) begin
      scnt     <= 0;
      valido   <= 1'b0;
      data_out <= '0;
    end else begin
      valido <= spur;
      if (spur) data_out <= 32'hDEAD_BEEF;
      if (validi) begin
        if (scnt == 0)      sa <= data_in;
        else if (scnt == 1) sb <= data_in;
        else begin
          valido   <= stub_en;
          data_out <= sa * sb + data_in;
        end
        scnt <= (scnt == 2) ? 0 : scnt + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Run one job end to end; returns the cycle stamp of the gnt pulse.
  task automatic run_job(input logic [3:0] rq, input logic [31:0] a, b, c,
                         input int eid, input logic [31:0] edata, input logic eerr,
                         input int ewait, input logic hold, output int gcyc);
    int   n;
    logic quiet;
    logic [3:0] eg;
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = rq[i] ? a : (32'hBAD0_0000 | i);
      req_b[i*32 +: 32] = rq[i] ? b : (32'hBAD1_0000 | i);
      req_c[i*32 +: 32] = rq[i] ? c : (32'hBAD2_0000 | i);
    end
    req = rq;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 4'b0 && n < 20);
    gcyc = cyc;
    eg = 4'b0001 << eid;
    chk("gnt", {28'b0, gnt}, {28'b0, eg});
    chk("din_a", data_in, a);
    chk("validi_a", {31'b0, validi}, 32'd1);
    if (!hold) req = req & ~gnt;
    @(negedge clk);
    chk("gnt_pulse", {28'b0, gnt}, 32'd0);
    chk("din_b", data_in, b);
    @(negedge clk);
    chk("din_c", data_in, c);
    chk("validi_c", {31'b0, validi}, 32'd1);
    n = 0;
    quiet = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (validi !== 1'b0 || data_in !== 32'd0) quiet = 1'b0;
    end while (!resp_valid && n < 40);
    chk("resp_latency", n, ewait);
    chk("bus_quiet", {31'b0, quiet}, 32'd1);
    chk("resp_id", {30'b0, resp_id}, eid);
    chk("resp_data", resp_data, edata);
    chk("resp_err", {31'b0, resp_err}, {31'b0, eerr});
    @(negedge clk);
    chk("resp_pulse", {31'b0, resp_valid}, 32'd0);
  endtask

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] a, b, c;
    int          eid;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int g0, g1, acc;
    logic [3:0] order [5];
    logic seen_resp;

    // RR pointer walks 0 -> 1 -> 2 -> 0 -> 1 -> 3 -> 0 across these vectors.
    tbl[0] = '{rq: 4'b0001, a: 32'd3,          b: 32'd4,  c: 32'd5,      eid: 0, ed: 32'd17};
    tbl[1] = '{rq: 4'b0010, a: 32'hFFFF_FFFF,  b: 32'd2,  c: 32'd3,      eid: 1, ed: 32'h0000_0001};
    tbl[2] = '{rq: 4'b1001, a: 32'd7,          b: 32'd6,  c: 32'd0,      eid: 3, ed: 32'd42};
    tbl[3] = '{rq: 4'b0001, a: 32'd10,         b: 32'd10, c: 32'd10,     eid: 0, ed: 32'd110};
    tbl[4] = '{rq: 4'b1100, a: 32'd1,          b: 32'd1,  c: 32'd1,      eid: 2, ed: 32'd2};
    tbl[5] = '{rq: 4'b1000, a: 32'd0,          b: 32'd0,  c: 32'h1234,   eid: 3, ed: 32'h1234};

    do_reset();
    chk("rst_gnt",        {28'b0, gnt},        32'd0);
    chk("rst_validi",     {31'b0, validi},     32'd0);
    chk("rst_data_in",    data_in,             32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_id",    {30'b0, resp_id},    32'd0);
    chk("rst_resp_data",  resp_data,           32'd0);
    chk("rst_resp_err",   {31'b0, resp_err},   32'd0);

    for (int v = 0; v < 6; v++)
      run_job(tbl[v].rq, tbl[v].a, tbl[v].b, tbl[v].c, tbl[v].eid, tbl[v].ed, 1'b0, 2, 1'b0, g0);
    req = '0;

    // Contention from reset: id0 then id2, back to back.
    req = 4'b0101;
    do_reset();
    run_job(4'b0101, 32'd2, 32'd3, 32'd1, 0, 32'd7, 1'b0, 2, 1'b0, g0);
    run_job(4'b0100, 32'd2, 32'd3, 32'd1, 2, 32'd7, 1'b0, 2, 1'b0, g1);
    chk("job_period", g1 - g0, 6);
    req = '0;

    // Fairness with every requester held high.
    do_reset();
    order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    for (int k = 0; k < 5; k++)
      run_job(4'b1111, 32'd1, 32'd2, 32'd3, int'(order[k]), 32'd5, 1'b0, 2, 1'b1, g0);
    req = '0;

    // Timeout: stub silent, response 8 cycles after WAIT entry, then normal job.
    stub_en = 1'b0;
    run_job(4'b0001, 32'd5, 32'd5, 32'd5, 0, 32'd0, 1'b1, 9, 1'b0, g0);
    stub_en = 1'b1;
    run_job(4'b0010, 32'd2, 32'd2, 32'd2, 1, 32'd6, 1'b0, 2, 1'b0, g0);

    // Spurious valido while idle must not produce a response.
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    acc = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || validi !== 1'b0) acc++;
    end
    chk("spurious_valido", acc, 0);

    // Reset while data_in carries b.
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'd9;
      req_b[i*32 +: 32] = 32'd8;
      req_c[i*32 +: 32] = 32'd7;
    end
    req = 4'b0100;
    acc = 0;
    do begin @(negedge clk); acc++; end while (gnt == 4'b0 && acc < 20);
    chk("mid_gnt", {28'b0, gnt}, 32'b0100);
    req = '0;
    @(negedge clk);
    chk("mid_din_b", data_in, 32'd8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_validi",  {31'b0, validi},  32'd0);
    chk("mid_data_in", data_in,          32'd0);
    chk("mid_outputs", {26'b0, gnt, resp_valid, resp_err} | resp_data | {30'b0, resp_id}, 32'd0);
    seen_resp = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid) seen_resp = 1'b1;
    end
    chk("mid_no_resp", {31'b0, seen_resp}, 32'd0);
    run_job(4'b1010, 32'd4, 32'd5, 32'd6, 1, 32'd26, 1'b0, 2, 1'b0, g0);
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
